sdrc_req_arb: RTL



---
 rtl/sdrc_req_arb_pkg.sv | 16 +
 rtl/sdrc_req_arb_if.sv | 40 ++++
 rtl/sdrc_rr_pick.sv | 33 +++
 rtl/sdrc_req_arb.sv | 111 +++++++++++
 4 files changed

// File: rtl/sdrc_req_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: request ID width,
// arbiter state encoding and a modulo-increment helper for the round-robin pointer.
package sdrc_req_arb_pkg;

  localparam int SDR_REQ_ID_W = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 32'd0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdrc_req_arb_if.sv
// Bus between the NP requesting masters / SDRAM request generator and the arbiter.
// master = environment view, slave = arbiter view.
interface sdrc_req_arb_if
  import sdrc_req_arb_pkg::*;
#(
  parameter int NP     = 4,
  parameter int PIDX_W = 2,
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int ID_W   = SDR_REQ_ID_W
);
  logic [NP-1:0]        p_req;
  logic [NP*ID_W-1:0]   p_id;
  logic [NP*APP_AW-1:0] p_addr;
  logic [NP*APP_RW-1:0] p_len;
  logic [NP-1:0]        p_wr_n;
  logic [NP-1:0]        p_wrap;
  logic [NP-1:0]        p_ack;

  logic                 req;
  logic [ID_W-1:0]      req_id;
  logic [APP_AW-1:0]    req_addr;
  logic [APP_RW-1:0]    req_len;
  logic                 req_wr_n;
  logic                 req_wrap;
  logic                 req_ack;

  logic [PIDX_W-1:0]    gnt_port;
  logic                 arb_idle;

  modport master (
    output p_req, p_id, p_addr, p_len, p_wr_n, p_wrap, req_ack,
    input  p_ack, req, req_id, req_addr, req_len, req_wr_n, req_wrap, gnt_port, arb_idle
  );

  modport slave (
    input  p_req, p_id, p_addr, p_len, p_wr_n, p_wrap, req_ack,
    output p_ack, req, req_id, req_addr, req_len, req_wr_n, req_wrap, gnt_port, arb_idle
  );
endinterface

// File: rtl/sdrc_rr_pick.sv
// Combinational round-robin picker: first eligible requester scanning upward
// from rr, modulo NP.
module sdrc_rr_pick #(
  parameter int NP     = 4,
  parameter int PIDX_W = 2
) (
  input  logic [NP-1:0]     req,
  input  logic [NP-1:0]     elig,
  input  logic [PIDX_W-1:0] rr,
  output logic [NP-1:0]     gnt_oh,
  output logic [PIDX_W-1:0] gnt_idx,
  output logic              gnt_vld
);
  logic [NP-1:0] cand;

  assign cand = req & elig;

  always_comb begin
    logic [PIDX_W-1:0] kidx;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    kidx    = '0;
    for (int i = 0; i < NP; i++) begin
      kidx = PIDX_W'((32'(rr) + 32'(i)) % 32'(NP));
      if (!gnt_vld && cand[kidx]) begin
        gnt_vld       = 1'b1;
        gnt_oh[kidx]  = 1'b1;
        gnt_idx       = kidx;
      end
    end
  end
endmodule

// File: rtl/sdrc_req_arb.sv
// Round-robin arbiter sharing the SDRAM request channel among NP masters.
// Define SDRC_ARB_PRIO_EN to add per-port 2-bit priorities (cfg_port_prio).
module sdrc_req_arb
  import sdrc_req_arb_pkg::*;
#(
  parameter int NP     = 4,
  parameter int PIDX_W = 2,
  parameter int APP_AW = 30,
  parameter int APP_RW = 9,
  parameter int ID_W   = SDR_REQ_ID_W
) (
  input  logic           clk,
  input  logic           reset_n,
`ifdef SDRC_ARB_PRIO_EN
  input  logic [NP*2-1:0] cfg_port_prio,
`endif
  sdrc_req_arb_if.slave  bus
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [APP_AW-1:0] addr;
    logic [APP_RW-1:0] len;
    logic              wr_n;
    logic              wrap;
  } req_t;

  localparam req_t REQ_RST = '{id: '0, addr: '0, len: '0, wr_n: 1'b1, wrap: 1'b0};

  arb_state_e        state, state_nxt;
  req_t [NP-1:0]     port_req;
  req_t              req_q;
  logic [NP-1:0]     elig, pick_oh, gnt_oh_q;
  logic [PIDX_W-1:0] pick_idx, gnt_q, rr;
  logic              pick_vld, ack_fire;

  for (genvar k = 0; k < NP; k++) begin : g_port
    assign port_req[k] = '{id:   bus.p_id[k*ID_W +: ID_W],
                           addr: bus.p_addr[k*APP_AW +: APP_AW],
                           len:  bus.p_len[k*APP_RW +: APP_RW],
                           wr_n: bus.p_wr_n[k],
                           wrap: bus.p_wrap[k]};
  end

`ifdef SDRC_ARB_PRIO_EN
  // Only the highest-priority requesters compete; round-robin breaks ties.
  logic [1:0] max_prio;
  always_comb begin
    max_prio = 2'd0;
    elig     = '0;
    for (int k = 0; k < NP; k++)
      if (bus.p_req[k] && cfg_port_prio[2*k +: 2] > max_prio)
        max_prio = cfg_port_prio[2*k +: 2];
    for (int k = 0; k < NP; k++)
      elig[k] = (cfg_port_prio[2*k +: 2] == max_prio);
  end
`else
  assign elig = '1;
`endif

  sdrc_rr_pick #(.NP(NP), .PIDX_W(PIDX_W)) u_pick (
    .req     (bus.p_req),
    .elig    (elig),
    .rr      (rr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Reset gating keeps p_ack quiet while a pending grant is being discarded.
  assign ack_fire = reset_n & (state == ARB_GRANT) & bus.req_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_vld)    state_nxt = ARB_GRANT;
      ARB_GRANT: if (bus.req_ack) state_nxt = ARB_IDLE;
      default:                    state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      rr       <= '0;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      req_q    <= REQ_RST;
    end else begin
      state <= state_nxt;
      if (state == ARB_IDLE && pick_vld) begin
        req_q    <= port_req[pick_idx];
        gnt_q    <= pick_idx;
        gnt_oh_q <= pick_oh;
      end
      if (ack_fire)
        rr <= PIDX_W'(wrap_inc(32'(gnt_q), 32'(NP)));
    end
  end

  assign bus.p_ack    = ack_fire ? gnt_oh_q : '0;
  assign bus.req      = (state == ARB_GRANT);
  assign bus.req_id   = req_q.id;
  assign bus.req_addr = req_q.addr;
  assign bus.req_len  = req_q.len;
  assign bus.req_wr_n = req_q.wr_n;
  assign bus.req_wrap = req_q.wrap;
  assign bus.gnt_port = gnt_q;
  assign bus.arb_idle = (state == ARB_IDLE) & ~|bus.p_req;

endmodule
